// File: rtl/clock_divider_if.sv
// Output bundle of the timebase: divided square-wave clocks and time-of-day counts.
// The divider drives it through the master modport; consumers use the slave modport.
`timescale 1ns/1ps
interface clock_divider_if;
  logic       D_2us_clk;
  logic       D_1ms_clk;
  logic       D_1s_clk;
  logic       D_1m_clk;
  logic       D_1h_clk;
  logic       D_1d_clk;
  logic [5:0] clk_1s_count;
  logic [5:0] clk_1m_count;
  logic [4:0] clk_1h_count;
  logic [9:0] clk_1d_count;

  modport master (
    output D_2us_clk, D_1ms_clk, D_1s_clk, D_1m_clk, D_1h_clk, D_1d_clk,
    output clk_1s_count, clk_1m_count, clk_1h_count, clk_1d_count
  );

  modport slave (
    input D_2us_clk, D_1ms_clk, D_1s_clk, D_1m_clk, D_1h_clk, D_1d_clk,
    input clk_1s_count, clk_1m_count, clk_1h_count, clk_1d_count
  );
endinterface

// File: rtl/clock_divider.sv
// Free-running timebase: cascaded prescalers to 2 us / 1 ms / 1 s, then a binary
// sec/min/hour/day counter, with registered 50%-duty divided clocks at every level.
`timescale 1ns/1ps
module clock_divider #(
  parameter int unsigned DIV_2US = 100,
  parameter int unsigned DIV_1MS = 500,
  parameter int unsigned DIV_1S  = 1000
) (
  input  logic             clk,
  input  logic             x_clr,
  clock_divider_if.master  bus
);

  localparam int unsigned P2_W = (DIV_2US > 1) ? $clog2(DIV_2US) : 1;
  localparam int unsigned PM_W = (DIV_1MS > 1) ? $clog2(DIV_1MS) : 1;
  localparam int unsigned PS_W = (DIV_1S  > 1) ? $clog2(DIV_1S)  : 1;

  localparam logic [P2_W-1:0] P2_MAX  = P2_W'(DIV_2US - 1);
  localparam logic [P2_W-1:0] P2_HALF = P2_W'(DIV_2US / 2);
  localparam logic [P2_W-1:0] P2_ONE  = P2_W'(1);
  localparam logic [PM_W-1:0] PM_MAX  = PM_W'(DIV_1MS - 1);
  localparam logic [PM_W-1:0] PM_HALF = PM_W'(DIV_1MS / 2);
  localparam logic [PM_W-1:0] PM_ONE  = PM_W'(1);
  localparam logic [PS_W-1:0] PS_MAX  = PS_W'(DIV_1S - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(DIV_1S / 2);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [P2_W-1:0] p2_q, p2_d;
  logic [PM_W-1:0] pm_q, pm_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hr_q, hr_d;
  logic [9:0]      day_q, day_d;
  logic            d2us_q, d2us_d;
  logic            d1ms_q, d1ms_d;
  logic            d1s_q, d1s_d;
  logic            d1m_q, d1m_d;
  logic            d1h_q, d1h_d;
  logic            d1d_q, d1d_d;

  logic tick_2us_s, tick_1ms_s, tick_1s_s, tick_1m_s, tick_1h_s, tick_1d_s;

  // Next-state of the whole cascade; every carry of one chain lands on the same edge.
  always_comb begin
    tick_2us_s = (p2_q == P2_MAX);
    tick_1ms_s = tick_2us_s && (pm_q == PM_MAX);
    tick_1s_s  = tick_1ms_s && (ps_q == PS_MAX);
    tick_1m_s  = tick_1s_s  && (sec_q == 6'd59);
    tick_1h_s  = tick_1m_s  && (min_q == 6'd59);
    tick_1d_s  = tick_1h_s  && (hr_q == 5'd23);

    p2_d  = tick_2us_s ? '0 : p2_q + P2_ONE;
    pm_d  = tick_1ms_s ? '0 : (tick_2us_s ? pm_q + PM_ONE : pm_q);
    ps_d  = tick_1s_s  ? '0 : (tick_1ms_s ? ps_q + PS_ONE : ps_q);
    sec_d = tick_1m_s  ? 6'd0 : (tick_1s_s ? sec_q + 6'd1 : sec_q);
    min_d = tick_1h_s  ? 6'd0 : (tick_1m_s ? min_q + 6'd1 : min_q);
    hr_d  = tick_1d_s  ? 5'd0 : (tick_1h_s ? hr_q + 5'd1 : hr_q);
    day_d = tick_1d_s  ? day_q + 10'd1 : day_q;

    // Divided clocks follow the next counter value so they register alongside it.
    d2us_d = (p2_d >= P2_HALF);
    d1ms_d = (pm_d >= PM_HALF);
    d1s_d  = (ps_d >= PS_HALF);
    d1m_d  = (sec_d >= 6'd30);
    d1h_d  = (min_d >= 6'd30);
    d1d_d  = (hr_d >= 5'd12);
  end

  // State registers with asynchronous clear of every counter and divided clock.
  always_ff @(posedge clk or negedge x_clr) begin
    if (!x_clr) begin
      p2_q   <= '0;
      pm_q   <= '0;
      ps_q   <= '0;
      sec_q  <= 6'd0;
      min_q  <= 6'd0;
      hr_q   <= 5'd0;
      day_q  <= 10'd0;
      d2us_q <= 1'b0;
      d1ms_q <= 1'b0;
      d1s_q  <= 1'b0;
      d1m_q  <= 1'b0;
      d1h_q  <= 1'b0;
      d1d_q  <= 1'b0;
    end else begin
      p2_q   <= p2_d;
      pm_q   <= pm_d;
      ps_q   <= ps_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      day_q  <= day_d;
      d2us_q <= d2us_d;
      d1ms_q <= d1ms_d;
      d1s_q  <= d1s_d;
      d1m_q  <= d1m_d;
      d1h_q  <= d1h_d;
      d1d_q  <= d1d_d;
    end
  end

  assign bus.D_2us_clk    = d2us_q;
  assign bus.D_1ms_clk    = d1ms_q;
  assign bus.D_1s_clk     = d1s_q;
  assign bus.D_1m_clk     = d1m_q;
  assign bus.D_1h_clk     = d1h_q;
  assign bus.D_1d_clk     = d1d_q;
  assign bus.clk_1s_count = sec_q;
  assign bus.clk_1m_count = min_q;
  assign bus.clk_1h_count = hr_q;
  assign bus.clk_1d_count = day_q;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: a default-parameter instance for the 2 us waveform and a
// small-parameter instance (1 s = 16 clk) whose seconds ticks feed a scoreboard.
`timescale 1ns/1ps
module tb_clock_divider;

  logic clk;
  logic x_clr;

  clock_divider_if bus_def ();
  clock_divider_if bus_sml ();

  clock_divider dut_def (
    .clk   (clk),
    .x_clr (x_clr),
    .bus   (bus_def)
  );

  clock_divider #(.DIV_2US(4), .DIV_1MS(2), .DIV_1S(2)) dut_sml (
    .clk   (clk),
    .x_clr (x_clr),
    .bus   (bus_sml)
  );

  typedef struct {
    int at;
    int ss;
    int mm;
    int hh;
    int dd;
    bit d1m;
    bit d1h;
    bit d1d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   edge_no   = 0;
  int   rel_edge  = 0;
  int   epoch     = 0;

  logic [32:0] def_all;
  logic [32:0] sml_all;

  assign def_all = {bus_def.D_2us_clk, bus_def.D_1ms_clk, bus_def.D_1s_clk,
                    bus_def.D_1m_clk, bus_def.D_1h_clk, bus_def.D_1d_clk,
                    bus_def.clk_1s_count, bus_def.clk_1m_count,
                    bus_def.clk_1h_count, bus_def.clk_1d_count};
  assign sml_all = {bus_sml.D_2us_clk, bus_sml.D_1ms_clk, bus_sml.D_1s_clk,
                    bus_sml.D_1m_clk, bus_sml.D_1h_clk, bus_sml.D_1d_clk,
                    bus_sml.clk_1s_count, bus_sml.clk_1m_count,
                    bus_sml.clk_1h_count, bus_sml.clk_1d_count};

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Seconds tick n (small instance) lands 16*n edges after release.
  task automatic push_exp(input int n);
    exp_t e;
    e.at  = 16 * n;
    e.ss  = n % 60;
    e.mm  = (n / 60) % 60;
    e.hh  = (n / 3600) % 24;
    e.dd  = n / 86400;
    e.d1m = (e.ss >= 30);
    e.d1h = (e.mm >= 30);
    e.d1d = (e.hh >= 12);
    exp_q.push_back(e);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every change of the seconds count is one DUT output event.
  initial begin
    int   prev_sec;
    int   seen_epoch;
    int   rel;
    exp_t e;
    logic [63:0] act;
    logic [63:0] expv;
    prev_sec   = 0;
    seen_epoch = 0;
    forever begin
      @(negedge clk);
      if (seen_epoch != epoch) begin
        seen_epoch = epoch;
        prev_sec   = int'(bus_sml.clk_1s_count);
      end else if (int'(bus_sml.clk_1s_count) != prev_sec) begin
        prev_sec = int'(bus_sml.clk_1s_count);
        rel = edge_no - rel_edge;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: seconds changed to %0d at edge %0d, expected no change",
                   bus_sml.clk_1s_count, rel);
        end else begin
          e = exp_q.pop_front();
          act  = {2'b00, 32'(rel), bus_sml.clk_1h_count, bus_sml.clk_1m_count,
                  bus_sml.clk_1s_count, bus_sml.clk_1d_count,
                  bus_sml.D_1m_clk, bus_sml.D_1h_clk, bus_sml.D_1d_clk};
          expv = {2'b00, 32'(e.at), 5'(e.hh), 6'(e.mm), 6'(e.ss), 10'(e.dd),
                  e.d1m, e.d1h, e.d1d};
          chk("sb_tick", act, expv);
        end
      end
    end
  end

  logic [3:0] vec_tab [5];
  int         vec_rel [5];

  initial begin
    int   rise1, rise2, fall1, fall2;
    logic prv, cur;

    x_clr = 1'b0;
    #290;
    chk("reset_def_all", 64'(def_all), 64'd0);
    chk("reset_sml_all", 64'(sml_all), 64'd0);

    for (int n = 1; n <= 37; n++) push_exp(n);
    @(negedge clk);
    #3;
    x_clr    = 1'b1;
    rel_edge = edge_no;

    rise1 = -1; rise2 = -1; fall1 = -1; fall2 = -1;
    prv = 1'b0;
    for (int r = 1; r <= 250; r++) begin
      @(negedge clk);
      cur = bus_def.D_2us_clk;
      if (r == 1) begin
        chk("edge1_p2", 64'(dut_def.p2_q), 64'd1);
        chk("edge1_outputs", 64'(def_all), 64'd0);
      end
      if (cur && !prv) begin
        if (rise1 < 0) rise1 = r;
        else if (rise2 < 0) rise2 = r;
      end
      if (!cur && prv) begin
        if (fall1 < 0) fall1 = r;
        else if (fall2 < 0) fall2 = r;
      end
      prv = cur;
    end
    chk("d2us_rise1", 64'(rise1), 64'd50);
    chk("d2us_fall1", 64'(fall1), 64'd100);
    chk("d2us_rise2", 64'(rise2), 64'd150);
    chk("d2us_fall2", 64'(fall2), 64'd200);

    drain(700);
    chk("sec_before_clear", 64'(bus_sml.clk_1s_count), 64'd37);

    // Restart phase: full hour of ticks, then a mid-cycle 1 ns clear pulse.
    for (int n = 1; n <= 3600; n++) push_exp(n);
    #2;
    x_clr = 1'b0;
    #0.5;
    chk("async_clr_sml", 64'(sml_all), 64'd0);
    chk("async_clr_def", 64'(def_all), 64'd0);
    #0.5;
    x_clr    = 1'b1;
    epoch    = epoch + 1;
    rel_edge = edge_no;

    // {D_2us, D_1ms, D_1s, sec[0]} at hand-picked edges after release
    vec_rel[0] = 2;  vec_tab[0] = 4'b1000;
    vec_rel[1] = 4;  vec_tab[1] = 4'b0100;
    vec_rel[2] = 8;  vec_tab[2] = 4'b0010;
    vec_rel[3] = 15; vec_tab[3] = 4'b1110;
    vec_rel[4] = 16; vec_tab[4] = 4'b0001;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (vec_rel[k] == r)
          chk($sformatf("small_wave_e%0d", r),
              64'({bus_sml.D_2us_clk, bus_sml.D_1ms_clk, bus_sml.D_1s_clk,
                   bus_sml.clk_1s_count[0]}),
              64'(vec_tab[k]));
      end
    end

    drain(57700);
    chk("final_hms", 64'({bus_sml.clk_1h_count, bus_sml.clk_1m_count, bus_sml.clk_1s_count}),
        64'({5'd1, 6'd0, 6'd0}));
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Free-running timebase and time-of-day counter driven by a single 50 MHz system clock (20 ns period).
- Cascaded prescalers produce divided square-wave clocks at 2 us, 1 ms, 1 s, 1 min, 1 h and 1 day.
- Also keeps binary second/minute/hour/day counts for display and monitoring logic.
- Sits at the top of the clock/timer subsystem.

Parameters:
- DIV_2US, 100, clk cycles per 2 us period; even, >=2.
- DIV_1MS, 500, 2 us periods per 1 ms period; even, >=2.
- DIV_1S, 1000, 1 ms periods per 1 s period; even, >=2.

Ports:
- clk  input  1  system clock, rising-edge active.
- x_clr  input  1  asynchronous active-low reset (clear).
- D_2us_clk  output  1  divided clock, period DIV_2US clk cycles.
- D_1ms_clk  output  1  divided clock, period 1 ms.
- D_1s_clk  output  1  divided clock, period 1 s.
- D_1m_clk  output  1  divided clock, period 60 s.
- D_1h_clk  output  1  divided clock, period 60 min.
- D_1d_clk  output  1  divided clock, period 24 h.
- clk_1s_count  output  6  seconds, 0..59.
- clk_1m_count  output  6  minutes, 0..59.
- clk_1h_count  output  5  hours, 0..23.
- clk_1d_count  output  10  days, 0..1023.

Behaviour:
- Reset:
  - x_clr=0 asynchronously clears all internal prescale counters, all count outputs and all D_*_clk outputs to 0.
  - While x_clr=0 everything holds 0.
  - Counting resumes on the first clk rising edge after x_clr goes to 1.
- All state and all outputs are registered on posedge clk; no combinational outputs.
- p2 (0..DIV_2US-1):
  - Increments every clk edge.
  - Wraps to 0 after DIV_2US-1; the wrap is the 2 us tick.
- pm (0..DIV_1MS-1): increments on each 2 us tick; its wrap is the 1 ms tick.
- ps (0..DIV_1S-1): increments on each 1 ms tick; its wrap is the 1 s tick.
- clk_1s_count:
  - Increments on each 1 s tick.
  - 59 -> 0 generates the minute tick.
- clk_1m_count:
  - Increments on the minute tick.
  - 59 -> 0 generates the hour tick.
- clk_1h_count:
  - Increments on the hour tick.
  - 23 -> 0 generates the day tick.
- clk_1d_count:
  - Increments on the day tick.
  - Wraps 1023 -> 0 silently.
- All ticks of one cascade chain take effect on the same clk edge. Example: at 23:59:59 with all prescalers at max, the next edge gives 00:00:00 and day+1.
- Divided clocks are 50% duty. Each is low for the first half of its period and high for the second half, relative to the counter it is derived from, and is registered alongside that counter:
  - D_2us_clk = 1 iff p2 >= DIV_2US/2
  - D_1ms_clk = 1 iff pm >= DIV_1MS/2
  - D_1s_clk = 1 iff ps >= DIV_1S/2
  - D_1m_clk = 1 iff clk_1s_count >= 30
  - D_1h_clk = 1 iff clk_1m_count >= 30
  - D_1d_clk = 1 iff clk_1h_count >= 12
- Consequences:
  - The falling edge of each divided clock coincides with the increment of the next-level count.
  - The rising edge falls mid-period, so counts are stable at every posedge of D_1s_clk, D_1m_clk, etc.
- Default timing: first D_2us_clk rise is 50 clk edges after reset release, then every 100 edges. D_1s_clk period is 50,000,000 clk cycles.
- Reset asserted mid-count: immediate clear with no partial-tick carry; restart from 00:00:00, day 0.

Test Plan:
- Reset: drive x_clr=0 for 300 ns while clk runs -> all outputs 0. Release -> after 1 edge p2=1, all counts still 0, D_2us_clk=0. Default parameters.
- Prescaler waveform, defaults: measure D_2us_clk after release -> first rise at edge 50, period 100 clk cycles (2 us), duty 50/50.
- Seconds cascade, DIV_2US=4, DIV_1MS=2, DIV_1S=2 (1 s = 16 clk cycles): D_1s_clk rises at edge 8 with clk_1s_count=0. clk_1s_count=1 at edge 16 with D_1s_clk falling on the same edge.
- Minute/hour rollover, same small parameters: after 960 edges -> second=0, minute=1. After 57,600 edges -> 1:00:00. D_1m_clk high exactly while seconds 30..59.
- Day rollover, same small parameters: run 1,382,400 edges -> 00:00:00 with clk_1d_count=1, all carries on one edge. D_1d_clk falls on that edge.
- Mid-operation reset: pulse x_clr low for 1 ns at 00:00:37 -> all outputs 0 immediately, without waiting for clk. Counting restarts cleanly; the next seconds increment occurs 16 edges after release.
